// File: rtl/spi_link_scheduler.sv
// spi_link_scheduler: arbitrates the shared SPI slave port between draining a
// received packet (RX) and loading/serialising one TX byte. Every output is a
// registered strobe/pulse/count.
// Optional feature macro SCHED_TIMEOUT_EN: when defined, the wait/transfer
// states abort to IDLE after TIMEOUT-1 cycles without a CS edge; when
// undefined, those states wait indefinitely and `timeout` stays 0.
module spi_link_scheduler #(
  parameter int unsigned BYTES_PER_PKT = 8,
  parameter int unsigned BITS_PER_BYTE = 8,
  parameter int unsigned TIMEOUT       = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pkt_rec,
  input  logic       CS,
  input  logic       tx_req,
  input  logic       bit_tick,
  output logic       mode,
  output logic       busy,
  output logic       pkt_ld,
  output logic       spi_ld,
  output logic       pkt_en,
  output logic       tx_ld,
  output logic       tx_en,
  output logic       rx_done,
  output logic       tx_done,
  output logic       timeout,
  output logic       ovf,
  output logic [3:0] byte_cnt,
  output logic [7:0] drop_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    RX_LOAD,
    RX_WAIT,
    RX_XFER,
    TX_WAIT,
    TX_XFER,
    TX_SHIFT
  } state_t;

  localparam logic [3:0] BYTES_INIT = 4'(BYTES_PER_PKT);
  localparam logic [3:0] BITS_LAST  = 4'(BITS_PER_BYTE);

  state_t      state_q, state_d;
  logic        pkt_q, cs_q;
  logic        mode_q, mode_d;
  logic        busy_q, busy_d;
  logic        pkt_ld_q, pkt_ld_d;
  logic        spi_ld_q, spi_ld_d;
  logic        pkt_en_q, pkt_en_d;
  logic        tx_ld_q, tx_ld_d;
  logic        tx_en_q, tx_en_d;
  logic        rx_done_q, rx_done_d;
  logic        tx_done_q, tx_done_d;
  logic        timeout_q, timeout_d;
  logic        ovf_q, ovf_d;
  logic [3:0]  byte_cnt_q, byte_cnt_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  drop_cnt_q, drop_cnt_d;
  logic        pkt_rise, cs_fall, cs_rise;
  logic        tmo_hit;
  logic [3:0]  bit_next;

`ifdef SCHED_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] tmo_q, tmo_d;

  assign tmo_hit = (tmo_q == TMO_LAST);

  // Timeout counter: restarts on any state change or CS edge, runs only in wait/xfer states.
  always_comb begin
    tmo_d = '0;
    if ((state_d != state_q) || cs_fall || cs_rise) begin
      tmo_d = '0;
    end else if ((state_q == RX_WAIT) || (state_q == RX_XFER) ||
                 (state_q == TX_WAIT) || (state_q == TX_XFER)) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  // Timeout counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  assign tmo_hit = (TIMEOUT == 0);
`endif

  assign pkt_rise = pkt_rec & ~pkt_q;
  assign cs_fall  = cs_q & ~CS;
  assign cs_rise  = ~cs_q & CS;
  assign bit_next = bit_cnt_q + 4'd1;

  // Next-state and next-output logic; strobes are computed one cycle early so they land registered.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    byte_cnt_d = byte_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    drop_cnt_d = drop_cnt_q;
    pkt_ld_d   = 1'b0;
    spi_ld_d   = 1'b0;
    pkt_en_d   = 1'b0;
    tx_ld_d    = 1'b0;
    tx_en_d    = 1'b0;
    rx_done_d  = 1'b0;
    tx_done_d  = 1'b0;
    timeout_d  = 1'b0;
    ovf_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (pkt_rise) begin
          state_d    = RX_LOAD;
          mode_d     = 1'b0;
          pkt_ld_d   = 1'b1;
          spi_ld_d   = 1'b1;
          byte_cnt_d = BYTES_INIT;
        end else if (tx_req) begin
          state_d = TX_WAIT;
          mode_d  = 1'b1;
        end
      end
      RX_LOAD: begin
        state_d = RX_WAIT;
      end
      RX_WAIT: begin
        if (cs_fall) begin
          state_d = RX_XFER;
        end else if (tmo_hit) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end
      end
      RX_XFER: begin
        if (cs_rise) begin
          pkt_en_d   = 1'b1;
          spi_ld_d   = 1'b1;
          byte_cnt_d = byte_cnt_q - 4'd1;
          if (byte_cnt_q == 4'd1) begin
            rx_done_d = 1'b1;
            state_d   = IDLE;
          end else begin
            state_d = RX_WAIT;
          end
        end else if (tmo_hit) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end
      end
      TX_WAIT: begin
        if (cs_fall) begin
          state_d = TX_XFER;
        end else if (tmo_hit) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end
      end
      TX_XFER: begin
        if (cs_rise) begin
          tx_ld_d   = 1'b1;
          bit_cnt_d = '0;
          state_d   = TX_SHIFT;
        end else if (tmo_hit) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end
      end
      TX_SHIFT: begin
        if (bit_tick) begin
          tx_en_d   = 1'b1;
          bit_cnt_d = bit_next;
          if (bit_next == BITS_LAST) begin
            tx_done_d = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (pkt_rise && (state_q != IDLE)) begin
      ovf_d = 1'b1;
      if (drop_cnt_q != '1) begin
        drop_cnt_d = drop_cnt_q + 8'd1;
      end
    end

    busy_d = (state_d != IDLE);
  end

  // State, edge-detect and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pkt_q      <= 1'b0;
      cs_q       <= 1'b1;
      mode_q     <= 1'b0;
      busy_q     <= 1'b0;
      pkt_ld_q   <= 1'b0;
      spi_ld_q   <= 1'b0;
      pkt_en_q   <= 1'b0;
      tx_ld_q    <= 1'b0;
      tx_en_q    <= 1'b0;
      rx_done_q  <= 1'b0;
      tx_done_q  <= 1'b0;
      timeout_q  <= 1'b0;
      ovf_q      <= 1'b0;
      byte_cnt_q <= '0;
      bit_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pkt_q      <= pkt_rec;
      cs_q       <= CS;
      mode_q     <= mode_d;
      busy_q     <= busy_d;
      pkt_ld_q   <= pkt_ld_d;
      spi_ld_q   <= spi_ld_d;
      pkt_en_q   <= pkt_en_d;
      tx_ld_q    <= tx_ld_d;
      tx_en_q    <= tx_en_d;
      rx_done_q  <= rx_done_d;
      tx_done_q  <= tx_done_d;
      timeout_q  <= timeout_d;
      ovf_q      <= ovf_d;
      byte_cnt_q <= byte_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign mode     = mode_q;
  assign busy     = busy_q;
  assign pkt_ld   = pkt_ld_q;
  assign spi_ld   = spi_ld_q;
  assign pkt_en   = pkt_en_q;
  assign tx_ld    = tx_ld_q;
  assign tx_en    = tx_en_q;
  assign rx_done  = rx_done_q;
  assign tx_done  = tx_done_q;
  assign timeout  = timeout_q;
  assign ovf      = ovf_q;
  assign byte_cnt = byte_cnt_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_spi_link_scheduler.sv
// Testbench for spi_link_scheduler (BYTES_PER_PKT=8, BITS_PER_BYTE=8, TIMEOUT=16).
// Honours SCHED_TIMEOUT_EN the same way the design does.
module tb_spi_link_scheduler;

  logic       clk = 1'b0;
  logic       rst, pkt_rec, CS, tx_req, bit_tick;
  logic       mode, busy, pkt_ld, spi_ld, pkt_en, tx_ld, tx_en;
  logic       rx_done, tx_done, timeout, ovf;
  logic [3:0] byte_cnt;
  logic [7:0] drop_cnt;

  always #5 clk = ~clk;

  spi_link_scheduler #(
    .BYTES_PER_PKT(8),
    .BITS_PER_BYTE(8),
    .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst), .pkt_rec(pkt_rec), .CS(CS), .tx_req(tx_req),
    .bit_tick(bit_tick), .mode(mode), .busy(busy), .pkt_ld(pkt_ld),
    .spi_ld(spi_ld), .pkt_en(pkt_en), .tx_ld(tx_ld), .tx_en(tx_en),
    .rx_done(rx_done), .tx_done(tx_done), .timeout(timeout), .ovf(ovf),
    .byte_cnt(byte_cnt), .drop_cnt(drop_cnt)
  );

  // Strobe bits: {pkt_ld, spi_ld, pkt_en, tx_ld, tx_en, rx_done, tx_done, timeout, ovf}
  localparam logic [8:0] PL = 9'h100;
  localparam logic [8:0] SL = 9'h080;
  localparam logic [8:0] PE = 9'h040;
  localparam logic [8:0] TL = 9'h020;
  localparam logic [8:0] TE = 9'h010;
  localparam logic [8:0] RD = 9'h008;
  localparam logic [8:0] TD = 9'h004;
  localparam logic [8:0] TO = 9'h002;
  localparam logic [8:0] OV = 9'h001;

  typedef struct packed {
    logic       mode;
    logic       busy;
    logic [8:0] st;
    logic [3:0] bc;
    logic [7:0] dc;
  } outs_t;

  typedef struct {
    logic       r, p, c, t, b;
    logic       mode, busy;
    logic [8:0] st;
    logic [3:0] bc;
    logic [7:0] dc;
  } vec_t;

  outs_t      sb[$];
  int         pass_cnt = 0;
  int         total_cnt = 0;
  logic       em;
  logic [3:0] eb;
  logic [7:0] ed;
  vec_t       tbl[10];

  function automatic outs_t mk(input logic bz, input logic [8:0] st);
    return {em, bz, st, eb, ed};
  endfunction

  task automatic step(input string name, input logic r, p, c, t, b, input outs_t e);
    outs_t got, want;
    rst = r; pkt_rec = p; CS = c; tx_req = t; bit_tick = b;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = {mode, busy, pkt_ld, spi_ld, pkt_en, tx_ld, tx_en, rx_done, tx_done,
           timeout, ovf, byte_cnt, drop_cnt};
    total_cnt++;
    if (sb.size() == 0) begin
      $display("FAIL %s: scoreboard empty, got=%h", name, got);
    end else begin
      want = sb.pop_front();
      if (got !== want) begin
        $display("FAIL %s @%0t: got mode=%b busy=%b st=%b bc=%0d dc=%0d, want mode=%b busy=%b st=%b bc=%0d dc=%0d",
                 name, $time, got.mode, got.busy, got.st, got.bc, got.dc,
                 want.mode, want.busy, want.st, want.bc, want.dc);
      end else begin
        pass_cnt++;
      end
    end
  endtask

  // One CS low/high frame while draining; the last byte also ends the drain.
  task automatic rx_frame(input string name);
    step(name, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, mk(1'b1, '0));
    eb = eb - 4'd1;
    if (eb == 4'd0) step(name, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, mk(1'b0, PE | SL | RD));
    else            step(name, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, mk(1'b1, PE | SL));
  endtask

  task automatic tx_start();
    em = 1'b1;
    step("tx_req", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, mk(1'b1, '0));
    step("tx_cs_fall", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mk(1'b1, '0));
    step("tx_ld", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, mk(1'b1, TL));
  endtask

  task automatic tx_bits(input logic wiggle_cs);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) step("tx_done", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, mk(1'b0, TE | TD));
      else        step("tx_en", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, mk(1'b1, TE));
      step("tx_gap", 1'b0, 1'b0, (wiggle_cs && i == 2) ? 1'b0 : 1'b1, 1'b0, 1'b0,
           mk(i != 7, '0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // r p c t b | mode busy strobes bc dc
    tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 4'd0, 8'd0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 9'h000, 4'd0, 8'd0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, PL | SL, 4'd8, 8'd0};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 9'h000, 4'd8, 8'd0};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9'h000, 4'd8, 8'd0};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, PE | SL, 4'd7, 8'd0};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 9'h000, 4'd7, 8'd0};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, OV,      4'd7, 8'd1};
    tbl[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9'h000, 4'd7, 8'd1};
    tbl[9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, PE | SL, 4'd6, 8'd1};

    // Reset, pkt high at release with simultaneous tx_req (RX wins), drop mid-drain.
    for (int i = 0; i < 10; i++) begin
      step($sformatf("table_row%0d", i), tbl[i].r, tbl[i].p, tbl[i].c, tbl[i].t, tbl[i].b,
           {tbl[i].mode, tbl[i].busy, tbl[i].st, tbl[i].bc, tbl[i].dc});
    end

    em = 1'b0; eb = 4'd6; ed = 8'd1;
    for (int k = 0; k < 6; k++) rx_frame("rx_drain");
    step("rx_idle", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, mk(1'b0, '0));

    // TX byte, CS toggling during shift must be ignored; mode holds 1 in IDLE.
    tx_start();
    tx_bits(1'b1);
    step("tx_idle_mode", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, mk(1'b0, '0));

    // Packet with CS held high.
    em = 1'b0; eb = 4'd8;
    step("to_pkt_ld", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, mk(1'b1, PL | SL));
    step("to_rx_wait", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, mk(1'b1, '0));
`ifdef SCHED_TIMEOUT_EN
    for (int k = 1; k < 16; k++) step("to_wait", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, mk(1'b1, '0));
    step("to_pulse", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, mk(1'b0, TO));
    step("to_after", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, mk(1'b0, '0));
`else
    for (int k = 0; k < 24; k++) step("no_to_hold", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, mk(1'b1, '0));
`endif

    // Reset mid-RX after 3 bytes, then a full drain with pkt high across reset release.
    em = 1'b0; eb = 4'd0; ed = 8'd0;
    step("rst_a", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, mk(1'b0, '0));
    eb = 4'd8;
    step("rx2_pkt_ld", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, mk(1'b1, PL | SL));
    step("rx2_load", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, mk(1'b1, '0));
    for (int k = 0; k < 3; k++) rx_frame("rx2_frame");
    step("rx2_cs_fall", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, mk(1'b1, '0));
    eb = 4'd0;
    step("rst_mid", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, mk(1'b0, '0));
    eb = 4'd8;
    step("rx3_pkt_ld", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, mk(1'b1, PL | SL));
    step("rx3_load", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, mk(1'b1, '0));
    for (int k = 0; k < 8; k++) rx_frame("rx3_frame");

    // 300 drops during a TX shift saturate drop_cnt at 255.
    tx_start();
    for (int n = 0; n < 300; n++) begin
      if (ed != 8'hFF) ed = ed + 8'd1;
      step("drop_rise", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, mk(1'b1, OV));
      step("drop_low", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, mk(1'b1, '0));
    end
    tx_bits(1'b0);
    step("final_idle", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, mk(1'b0, '0));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/spi_link_scheduler.md
# spi_link_scheduler

Sequencing controller for the transceiver datapath. It owns the shared SPI slave port and decides whether it is draining a received 64-bit packet from the packet register (RX) or loading and serialising one byte into the TX buffer (TX). It emits the single-cycle load and enable strobes for the packet register and TX buffer, counts bytes and bits, and reports drops and timeouts. It replaces the free-running RX/TX sequencing in the top level and sits between the dual buffer, packet register, SPI slave and TX buffer.

## Interface
- BYTES_PER_PKT, 8: bytes drained per received packet (2..15).
- BITS_PER_BYTE, 8: `bit_tick` strobes per TX byte (1..15).
- TIMEOUT, 1024: max `clk` cycles waiting for a CS edge before abort (≥2).
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- pkt_rec  in  1  packet-received level from the dual buffer; its rising edge is the event.
- CS  in  1  SPI chip select, active low, already synchronised to `clk`.
- tx_req  in  1  level request for a TX byte transfer.
- bit_tick  in  1  TX bit-rate strobe, one `clk` wide.
- mode  out  1  0 = RX, 1 = TX; drives the SPI slave mode select.
- busy  out  1  high in any state other than IDLE.
- pkt_ld  out  1  packet register load strobe.
- spi_ld  out  1  SPI data-register load strobe.
- pkt_en  out  1  packet register byte-advance strobe.
- tx_ld  out  1  TX buffer load strobe.
- tx_en  out  1  TX buffer shift enable.
- rx_done, tx_done, timeout, ovf  out  1 each  single-cycle event pulses.
- byte_cnt  out  4  RX bytes remaining.
- drop_cnt  out  8  saturating count of dropped packets.

## Operation
- States: IDLE, RX_LOAD, RX_WAIT, RX_XFER, TX_WAIT, TX_XFER, TX_SHIFT.
- Edge detection uses registered `pkt_q` and `cs_q`. pkt rise = `pkt_rec & ~pkt_q`. CS fall = `cs_q & ~CS`. CS rise = `~cs_q & CS`.
- IDLE: all strobes 0.
  - On pkt rise, go to RX_LOAD and set mode=0.
  - Otherwise, if `tx_req`, go to TX_WAIT and set mode=1.
  - If both occur in the same cycle, RX wins.
- RX_LOAD: pulse pkt_ld and spi_ld for one cycle. Load byte_cnt with BYTES_PER_PKT. Go to RX_WAIT.
- RX_WAIT: on CS fall, go to RX_XFER.
- RX_XFER: on CS rise:
  - pulse pkt_en and spi_ld, and decrement byte_cnt;
  - if byte_cnt was 1, pulse rx_done and go to IDLE; otherwise go to RX_WAIT.
- TX_WAIT: on CS fall, go to TX_XFER.
- TX_XFER: on CS rise, pulse tx_ld, clear bit_cnt and go to TX_SHIFT.
- TX_SHIFT: each `bit_tick` produces a one-cycle tx_en and increments bit_cnt.
  - When bit_cnt reaches BITS_PER_BYTE, pulse tx_done and go to IDLE.
  - CS is ignored in this state.
- A pkt rise in any non-IDLE state does not start RX. It pulses ovf and increments drop_cnt, saturating at 255.
- `mode` changes only on leaving IDLE. It holds its last value while in IDLE.

## Timing
- All outputs are registered. Every strobe appears on the cycle after the edge (`clk` sample) that causes it.
- Latencies:
  - pkt rise to pkt_ld: 1 cycle.
  - CS rise to pkt_en or tx_ld: 1 cycle.
  - bit_tick to tx_en: 1 cycle.
- Reset values:
  - state IDLE;
  - mode, busy, all strobes and pulses 0;
  - byte_cnt 0, drop_cnt 0, bit_cnt 0;
  - cs_q 1, pkt_q 0.
- A `pkt_rec` that is already high when reset is released counts as a rise on the first cycle after reset.
- Asserting rst mid-transfer aborts immediately. No done pulse is emitted, and drop_cnt clears.
- A CS fall and CS rise in consecutive cycles form a valid one-cycle transfer.
- The timeout counter clears on every state entry and on every CS edge.
  - If it reaches TIMEOUT-1 in RX_WAIT, RX_XFER, TX_WAIT or TX_XFER, pulse timeout and go to IDLE.
  - The counter is not used in TX_SHIFT.

## Configuration
- `SCHED_TIMEOUT_EN` defined: the timeout counter and abort path are compiled in, as described above.
- `SCHED_TIMEOUT_EN` undefined: no counter exists, the wait states hold indefinitely, and `timeout` is tied to 0.

## Test plan
- RX drain: pkt rise → pkt_ld/spi_ld at +1. Then 8 CS low/high frames → 8 pkt_en pulses, byte_cnt 8→0, rx_done on the 8th, busy low afterwards.
- TX byte: tx_req=1, then one CS frame → tx_ld 1 cycle after CS rise. Then 8 bit_ticks → 8 tx_en pulses, tx_done, mode=1.
- Collision and drop:
  - pkt rise and tx_req in the same cycle → RX selected, mode=0.
  - A second pkt rise mid-drain → ovf pulse, drop_cnt=1, drain continues.
  - 300 drops → drop_cnt saturates at 255.
- Timeout (macro on, TIMEOUT=16): pkt rise with CS held high → timeout pulse 16 cycles after entering RX_WAIT, state IDLE. With the macro off, the same stimulus stays in RX_WAIT forever.
- Reset mid-RX after 3 bytes → all outputs 0 on the next cycle, no rx_done. Then a new pkt rise drains a full 8 bytes.
